// File: rtl/dmux8_pkg.sv
// rtl/dmux8_pkg.sv - shared constants and channel state type for the 8-way stream demux
package dmux8_pkg;
    localparam int NCH   = 8;
    localparam int SEL_W = 3;
    localparam int WIDTH = 16;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_t;
endpackage

// File: rtl/dmux_chan_buf.sv
// rtl/dmux_chan_buf.sv - one-entry output buffer with load/drain FSM
module dmux_chan_buf
    import dmux8_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);
    chan_state_t state, next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CH_EMPTY;
            data  <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                data <= load_data;
            end
        end
    end

    // A load while FULL only arrives together with a drain, so the buffer stays FULL.
    always_comb begin
        next_state = state;
        case (state)
            CH_EMPTY: if (load) next_state = CH_FULL;
            CH_FULL:  if (ready && !load) next_state = CH_EMPTY;
            default:  next_state = CH_EMPTY;
        endcase
    end

    assign valid = (state == CH_FULL);
endmodule

// File: rtl/dmux8way16_stream.sv
// rtl/dmux8way16_stream.sv - registered 8-way 16-bit stream demux; DMUX8_PROTOCOL_CHECK_EN enables the stall checker
module dmux8way16_stream #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic                 err
);
    import dmux8_pkg::SEL_W;

    logic           accept;
    logic [NCH-1:0] load;

    // Only the selected channel gates the producer, so stalled neighbours never block.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign load[k] = accept && (in_sel == SEL_W'(k));

        dmux_chan_buf #(.W(WIDTH)) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*WIDTH +: WIDTH])
        );
    end

`ifdef DMUX8_PROTOCOL_CHECK_EN
    logic             prev_valid;
    logic             prev_ready;
    logic [WIDTH-1:0] prev_data;
    logic [SEL_W-1:0] prev_sel;
    logic             err_q;
    logic             violation;

    assign violation = prev_valid && !prev_ready &&
                       (!in_valid || (in_data != prev_data) || (in_sel != prev_sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_data  <= '0;
            prev_sel   <= '0;
            err_q      <= 1'b0;
        end else begin
            prev_valid <= in_valid;
            prev_ready <= in_ready;
            prev_data  <= in_data;
            prev_sel   <= in_sel;
            err_q      <= err_q | violation;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_dmux8way16_stream.sv
// tb/tb_dmux8way16_stream.sv - randomized self-checking bench with a per-channel occupancy model
module tb_dmux8way16_stream;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_valid [8];
    logic [15:0] m_data  [8];
    bit          m_err;
    bit          p_stall;
    logic [15:0] p_data;
    logic [2:0]  p_sel;

    always #5 clk = ~clk;

    dmux8way16_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    function automatic bit m_ready(input logic [2:0] sel);
        return !m_valid[sel] || out_ready[sel];
    endfunction

    function automatic logic [7:0] m_vvec();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [15:0] chan(input int k);
        return out_data[k*16 +: 16];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 16'h0000;
        end
        m_err   = 1'b0;
        p_stall = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [2:0] sel, input logic [15:0] d, input logic [7:0] ordy);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Advance the model by one clock from the current (stable) inputs, then step the DUT.
    task automatic tick();
        bit acc;
        acc = in_valid && m_ready(in_sel);
`ifdef DMUX8_PROTOCOL_CHECK_EN
        if (p_stall && (!in_valid || in_data != p_data || in_sel != p_sel)) m_err = 1'b1;
        p_stall = in_valid && !m_ready(in_sel);
        p_data  = in_data;
        p_sel   = in_sel;
`endif
        for (int k = 0; k < 8; k++) begin
            if (acc && in_sel == 3'(k)) begin
                m_valid[k] = 1'b1;
                m_data[k]  = in_data;
            end else if (m_valid[k] && out_ready[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 8'h00);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 8'h00) begin n_errors++; $display("FAIL reset_valid got %h exp 00", out_valid); end
        n_checks++;
        if (out_data !== 128'h0) begin n_errors++; $display("FAIL reset_data got %h exp 0", out_data); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", err); end
        rst_n = 1'b1;
        tick();
        drive(1'b1, 3'd3, 16'hC0DE, 8'h00);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 8'h00);
        n_checks++;
        if (out_valid !== 8'h08) begin n_errors++; $display("FAIL pre_reset_fill got %h exp 08", out_valid); end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (out_valid !== 8'h00) begin n_errors++; $display("FAIL async_reset_valid got %h exp 00", out_valid); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL async_reset_err got %b exp 0", err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_errors++; $display("FAIL idle_ready sel%0d got %b exp 1", s, in_ready); end
        end
        tick();
    endtask

    task automatic test_routing();
        logic [15:0] words [8];
        words = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB};
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), words[k], 8'h00);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_errors++; $display("FAIL route_ready ch%0d got %b exp 1", k, in_ready); end
            tick();
            n_checks++;
            if (out_valid[k] !== 1'b1 || chan(k) !== words[k]) begin
                n_errors++;
                $display("FAIL route_ch%0d got v=%b d=%h exp v=1 d=%h", k, out_valid[k], chan(k), words[k]);
            end
        end
        drive(1'b0, 3'd0, 16'h0000, 8'h00);
        #1;
        n_checks++;
        if (out_valid !== 8'hFF) begin n_errors++; $display("FAIL route_all got %h exp ff", out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 3'd2, 16'h4567, 8'h00);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall_ready got %b exp 0", in_ready); end
        tick();
        n_checks++;
        if (out_valid[2] !== 1'b1 || chan(2) !== 16'h3456) begin
            n_errors++;
            $display("FAIL bp_hold got v=%b d=%h exp v=1 d=3456", out_valid[2], chan(2));
        end
        out_ready = 8'h04;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        tick();
        drive(1'b0, 3'd0, 16'h0000, 8'h00);
        n_checks++;
        if (out_valid[2] !== 1'b1 || chan(2) !== 16'h4567) begin
            n_errors++;
            $display("FAIL bp_replace got v=%b d=%h exp v=1 d=4567", out_valid[2], chan(2));
        end
    endtask

    task automatic test_independence();
        drive(1'b0, 3'd0, 16'h0000, 8'h40);
        tick();
        n_checks++;
        if (out_valid !== 8'hBF) begin n_errors++; $display("FAIL indep_drain6 got %h exp bf", out_valid); end
        drive(1'b1, 3'd6, 16'h789A, 8'h00);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL indep_ready got %b exp 1", in_ready); end
        tick();
        drive(1'b0, 3'd0, 16'h0000, 8'h00);
        n_checks++;
        if (out_valid[6] !== 1'b1 || chan(6) !== 16'h789A) begin
            n_errors++;
            $display("FAIL indep_ch6 got v=%b d=%h exp v=1 d=789a", out_valid[6], chan(6));
        end
        n_checks++;
        if (out_valid[5] !== 1'b1 || chan(5) !== m_data[5]) begin
            n_errors++;
            $display("FAIL indep_ch5 got v=%b d=%h exp v=1 d=%h", out_valid[5], chan(5), m_data[5]);
        end
    endtask

    task automatic test_concurrent_drain();
        n_checks++;
        if (out_valid !== 8'hFF) begin n_errors++; $display("FAIL cdrain_pre got %h exp ff", out_valid); end
        drive(1'b0, 3'd0, 16'h0000, 8'hA5);
        tick();
        out_ready = 8'h00;
        n_checks++;
        if (out_valid !== 8'h5A) begin n_errors++; $display("FAIL cdrain got %h exp 5a", out_valid); end
    endtask

    task automatic test_random();
        bit held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 3'($urandom_range(0, 7));
                in_data  = 16'($urandom);
            end
            out_ready = 8'($urandom);
            held = in_valid && !m_ready(in_sel);
            #1;
            n_checks++;
            if (in_ready !== m_ready(in_sel)) begin
                n_errors++;
                $display("FAIL rand_ready cyc%0d got %b exp %b", i, in_ready, m_ready(in_sel));
            end
            tick();
            n_checks++;
            if (out_valid !== m_vvec()) begin
                n_errors++;
                $display("FAIL rand_valid cyc%0d got %h exp %h", i, out_valid, m_vvec());
            end
            for (int k = 0; k < 8; k++) begin
                if (m_valid[k]) begin
                    n_checks++;
                    if (chan(k) !== m_data[k]) begin
                        n_errors++;
                        $display("FAIL rand_data cyc%0d ch%0d got %h exp %h", i, k, chan(k), m_data[k]);
                    end
                end
            end
        end
        drive(1'b0, 3'd0, 16'h0000, 8'h00);
        tick();
    endtask

    task automatic test_protocol();
        rst_n = 1'b0;
        model_clear();
        #2;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 3'd4, 16'h1111, 8'h00);
        tick();
        drive(1'b1, 3'd4, 16'hAAAA, 8'h00);
        tick();
        drive(1'b1, 3'd4, 16'hBBBB, 8'h00);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 8'h00);
`ifdef DMUX8_PROTOCOL_CHECK_EN
        n_checks++;
        if (m_err !== 1'b1) begin n_errors++; $display("FAIL proto_model got %b exp 1", m_err); end
`endif
        n_checks++;
        if (err !== m_err) begin n_errors++; $display("FAIL proto_err got %b exp %b", err, m_err); end
        tick();
        tick();
        n_checks++;
        if (err !== m_err) begin n_errors++; $display("FAIL proto_sticky got %b exp %b", err, m_err); end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL proto_reset got %b exp 0", err); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_concurrent_drain();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
